// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates game sound requests by priority and plays a fixed melody per event on the amplifier pins.
// Optional feature macro SND_MUTE_EN adds a mute input that silences audio/notshutdown while playback keeps running.
module sound_sequencer #(
  parameter int HP_W      = 16,
  parameter int DUR_W     = 6,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slowen,
  input  logic       wingame,
  input  logic       winrnd,
  input  logic       foul,
  input  logic       sypush,
`ifdef SND_MUTE_EN
  input  logic       mute,
`endif
  output logic       audio,
  output logic       gain,
  output logic       notshutdown,
  output logic       busy,
  output logic [1:0] cur_evt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
    logic             last;
  } note_t;

  localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'(GAP_TICKS - 1);

  function automatic note_t note_lookup(input logic [1:0] evt, input logic [1:0] idx);
    note_t n;
    n.hp   = HP_W'(6250);
    n.dur  = DUR_W'(2);
    n.last = 1'b1;
    case (evt)
      2'd3: begin
        n.last = (idx == 2'd3);
        case (idx)
          2'd0:    begin n.hp = HP_W'(23900); n.dur = DUR_W'(8);  end
          2'd1:    begin n.hp = HP_W'(18968); n.dur = DUR_W'(8);  end
          2'd2:    begin n.hp = HP_W'(15944); n.dur = DUR_W'(8);  end
          default: begin n.hp = HP_W'(11944); n.dur = DUR_W'(16); end
        endcase
      end
      2'd2: begin
        n.last = (idx != 2'd0);
        if (idx == 2'd0) begin
          n.hp  = HP_W'(23900);
          n.dur = DUR_W'(8);
        end else begin
          n.hp  = HP_W'(15944);
          n.dur = DUR_W'(16);
        end
      end
      2'd1: begin
        n.hp  = HP_W'(56818);
        n.dur = DUR_W'(24);
      end
      default: begin
        n.hp  = HP_W'(6250);
        n.dur = DUR_W'(2);
      end
    endcase
    return n;
  endfunction

  function automatic logic [1:0] top_evt(input logic [3:0] v);
    if (v[3])      return 2'd3;
    else if (v[2]) return 2'd2;
    else if (v[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [1:0]        evt_q, evt_d;
  logic [1:0]        idx_q, idx_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [HP_W-1:0]   tone_q, tone_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  gap_q, gap_d;
  logic              audio_q, audio_d;

  logic [3:0] req;
  logic [3:0] higher_mask;
  logic [1:0] grant_evt;
  logic       preempt;
  logic       grant;
  note_t      cur_note;

  assign req         = {wingame, winrnd, foul, sypush};
  assign higher_mask = 4'(4'b1110 << evt_q);
  assign preempt     = |(pending_q & higher_mask);
  assign grant_evt   = top_evt(pending_q);
  assign cur_note    = note_lookup(evt_q, idx_q);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | req;
    evt_d     = evt_q;
    idx_d     = idx_q;
    hp_d      = hp_q;
    tone_d    = tone_q;
    dur_d     = dur_q;
    gap_d     = gap_q;
    audio_d   = 1'b0;
    grant     = 1'b0;

    unique case (state_q)
      S_IDLE: grant = |pending_q;
      S_LOAD: begin
        if (preempt) begin
          grant = 1'b1;
        end else begin
          hp_d    = cur_note.hp;
          dur_d   = cur_note.dur;
          tone_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (preempt) begin
          grant = 1'b1;
        end else begin
          if (tone_q == hp_q - HP_W'(1)) begin
            tone_d  = '0;
            audio_d = ~audio_q;
          end else begin
            tone_d  = tone_q + HP_W'(1);
            audio_d = audio_q;
          end
          if (slowen) begin
            if (dur_q <= DUR_W'(1)) begin
              audio_d = 1'b0;
              gap_d   = '0;
              if (cur_note.last) begin
                state_d = S_IDLE;
                evt_d   = 2'd0;
              end else begin
                state_d = S_GAP;
              end
            end else begin
              dur_d = dur_q - DUR_W'(1);
            end
          end
        end
      end
      S_GAP: begin
        if (preempt) begin
          grant = 1'b1;
        end else if (slowen) begin
          if (gap_q == GAP_LAST) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end else begin
            gap_d = gap_q + DUR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving on the grant edge re-arms its bit, so it is not lost.
    if (grant) begin
      state_d   = S_LOAD;
      evt_d     = grant_evt;
      idx_d     = 2'd0;
      audio_d   = 1'b0;
      pending_d = (pending_q & ~(4'(4'b0001 << grant_evt))) | req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      evt_q     <= 2'd0;
      idx_q     <= 2'd0;
      hp_q      <= '0;
      tone_q    <= '0;
      dur_q     <= '0;
      gap_q     <= '0;
      audio_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      evt_q     <= evt_d;
      idx_q     <= idx_d;
      hp_q      <= hp_d;
      tone_q    <= tone_d;
      dur_q     <= dur_d;
      gap_q     <= gap_d;
      audio_q   <= audio_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign gain    = busy & evt_q[1];
  assign cur_evt = busy ? evt_q : 2'd0;

`ifdef SND_MUTE_EN
  assign audio       = audio_q & ~mute;
  assign notshutdown = busy & ~mute;
`else
  assign audio       = audio_q;
  assign notshutdown = busy;
`endif

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random requests, compared every cycle against a note-schedule model.
module tb_sound_sequencer;
  localparam int GAP_TICKS = 1;
`ifdef SND_MUTE_EN
  localparam bit HAS_MUTE = 1'b1;
`else
  localparam bit HAS_MUTE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, slowen, wingame, winrnd, foul, sypush, mute;
  logic       audio, gain, notshutdown, busy;
  logic [1:0] cur_evt;

  sound_sequencer #(.HP_W(16), .DUR_W(6), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .rst(rst), .slowen(slowen),
    .wingame(wingame), .winrnd(winrnd), .foul(foul), .sypush(sypush),
`ifdef SND_MUTE_EN
    .mute(mute),
`endif
    .audio(audio), .gain(gain), .notshutdown(notshutdown), .busy(busy), .cur_evt(cur_evt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int slow_period = 64;

  // Reference model: phase 0 idle, 1 load, 2 play, 3 gap; audio derived from elapsed play cycles.
  int       m_phase, m_evt, m_idx, m_slow, m_cyc;
  bit [3:0] m_pend;
  int       mdl_log[$];
  int       dut_log[$];

  function automatic int note_hp(input int e, input int i);
    case (e)
      3: begin
        if (i == 0) return 23900;
        if (i == 1) return 18968;
        if (i == 2) return 15944;
        return 11944;
      end
      2: return (i == 0) ? 23900 : 15944;
      1: return 56818;
      default: return 6250;
    endcase
  endfunction

  function automatic int note_dur(input int e, input int i);
    case (e)
      3: return (i == 3) ? 16 : 8;
      2: return (i == 0) ? 8 : 16;
      1: return 24;
      default: return 2;
    endcase
  endfunction

  function automatic int n_notes(input int e);
    case (e)
      3: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit mute_eff();
    return HAS_MUTE && mute;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_evt = 0; m_idx = 0; m_slow = 0; m_cyc = 0; m_pend = 4'b0;
  endtask

  task automatic model_step();
    bit [3:0] r;
    int top;
    bit g;
    r   = {wingame, winrnd, foul, sypush};
    top = -1;
    for (int e = 3; e >= 0; e--) if (m_pend[e] && top < 0) top = e;
    g = (m_phase == 0) ? (top >= 0) : (top > m_evt);
    if (g) begin
      m_pend[top] = 1'b0;
      m_phase = 1; m_evt = top; m_idx = 0;
      mdl_log.push_back(top);
    end else begin
      case (m_phase)
        1: begin m_phase = 2; m_cyc = 0; m_slow = 0; end
        2: begin
          m_cyc++;
          if (slowen) begin
            m_slow++;
            if (m_slow == note_dur(m_evt, m_idx)) begin
              if (m_idx == n_notes(m_evt) - 1) begin m_phase = 0; m_evt = 0; end
              else begin m_phase = 3; m_slow = 0; end
            end
          end
        end
        3: if (slowen) begin
          m_slow++;
          if (m_slow == GAP_TICKS) begin m_idx++; m_phase = 1; end
        end
        default: ;
      endcase
    end
    m_pend = m_pend | r;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else begin
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
      if (n_checks - n_pass >= 40) begin
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison plus an observed-grant log taken from the DUT outputs.
  initial begin
    bit pb;
    int pe;
    bit eb;
    pb = 1'b0; pe = 0;
    forever begin
      @(posedge clk);
      #4;
      eb = (m_phase != 0);
      chk("busy", busy, eb);
      chk("cur_evt", cur_evt, eb ? m_evt : 0);
      chk("gain", gain, eb && m_evt >= 2);
      chk("notshutdown", notshutdown, eb && !mute_eff());
      chk("audio", audio,
          (m_phase == 2 && ((m_cyc / note_hp(m_evt, m_idx)) % 2) == 1) && !mute_eff());
      if (busy && (!pb || cur_evt != pe)) dut_log.push_back(cur_evt);
      pb = busy;
      pe = cur_evt;
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    slowen = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (slow_period == 0) slowen = ($urandom_range(7) == 0);
      else begin
        cnt++;
        if (cnt >= slow_period) begin cnt = 0; slowen = 1'b1; end
        else slowen = 1'b0;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, got %0d checks", n_checks);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic pulse(input bit [3:0] r);
    {wingame, winrnd, foul, sypush} = r;
    step(1);
    {wingame, winrnd, foul, sypush} = 4'b0;
  endtask

  task automatic wait_quiet(input string name, input int max_cyc);
    int q, n;
    q = 0; n = 0;
    while (q < 3 && n < max_cyc) begin
      step(1);
      n++;
      q = busy ? 0 : q + 1;
    end
    chk({name, "_idle_reached"}, (q >= 3), 1);
  endtask

  task automatic clear_logs();
    dut_log.delete();
    mdl_log.delete();
  endtask

  task automatic chk_order(input string name, input int n, input int e0, input int e1, input int e2);
    int exp[3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    chk({name, "_count"}, dut_log.size(), n);
    chk({name, "_model_count"}, mdl_log.size(), n);
    for (int i = 0; i < n; i++) begin
      chk({name, "_order"}, (i < dut_log.size()) ? dut_log[i] : -1, exp[i]);
      chk({name, "_model_order"}, (i < mdl_log.size()) ? mdl_log[i] : -1, exp[i]);
    end
  endtask

  initial begin
    int k;
    {wingame, winrnd, foul, sypush} = 4'b0;
    mute = 1'b0;
    rst  = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_audio", audio, 0);
    chk("rst_gain", gain, 0);
    chk("rst_notshutdown", notshutdown, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur_evt", cur_evt, 0);
    step(2);
    rst = 1'b1;
    step(2);

    // Reset in the middle of a wingame note.
    slow_period = 64;
    clear_logs();
    pulse(4'b1000);
    step(300);
    chk("t1_busy_before", busy, 1);
    chk("t1_cur_evt_before", cur_evt, 3);
    chk("t1_gain_before", gain, 1);
    rst = 1'b0;
    #1;
    chk("t1_audio", audio, 0);
    chk("t1_gain", gain, 0);
    chk("t1_notshutdown", notshutdown, 0);
    chk("t1_busy", busy, 0);
    chk("t1_cur_evt", cur_evt, 0);
    step(2);
    rst = 1'b1;
    step(600);
    chk("t1_no_replay", busy, 0);
    chk_order("t1", 1, 3, 0, 0);

    // sypush with slow notes so the first audio edge is visible.
    slow_period = 7000;
    clear_logs();
    pulse(4'b0001);
    chk("t2_busy_at_capture", busy, 0);
    step(1);
    chk("t2_busy_load", busy, 1);
    chk("t2_cur_evt", cur_evt, 0);
    chk("t2_gain", gain, 0);
    k = 1;
    while (!audio && k < 20000) begin step(1); k++; end
    chk("t2_first_rise_cycles", k, 6252);
    wait_quiet("t2", 25000);
    chk_order("t2", 1, 0, 0, 0);

    // winrnd two-note melody.
    slow_period = 256;
    clear_logs();
    pulse(4'b0100);
    step(2);
    chk("t3_gain", gain, 1);
    chk("t3_cur_evt", cur_evt, 2);
    wait_quiet("t3", 12000);
    chk_order("t3", 1, 2, 0, 0);

    // wingame preempts foul.
    slow_period = 64;
    clear_logs();
    pulse(4'b0010);
    step(200);
    chk("t4_foul_playing", cur_evt, 1);
    pulse(4'b1000);
    chk("t4_not_yet", cur_evt, 1);
    step(1);
    chk("t4_preempted", cur_evt, 3);
    chk("t4_audio_forced", audio, 0);
    wait_quiet("t4", 6000);
    chk_order("t4", 2, 1, 3, 0);

    // Lower-priority requests queue behind winrnd.
    clear_logs();
    pulse(4'b0100);
    step(100);
    pulse(4'b0011);
    step(1);
    chk("t5_no_preempt", cur_evt, 2);
    wait_quiet("t5", 8000);
    chk_order("t5", 3, 2, 1, 0);

    // Simultaneous requests, muted when the mute port exists.
    clear_logs();
    mute = HAS_MUTE;
    pulse(4'b1101);
    step(1);
    chk("t6_first", cur_evt, 3);
    wait_quiet("t6", 8000);
    chk_order("t6", 3, 3, 2, 0);
    mute = 1'b0;

    // Repeated re-requests of the playing event collapse into one replay.
    clear_logs();
    pulse(4'b0001);
    step(5);
    pulse(4'b0001);
    step(5);
    pulse(4'b0001);
    wait_quiet("t7", 2000);
    chk_order("t7", 2, 0, 0, 0);

    // Random traffic.
    slow_period = 0;
    for (int c = 0; c < 20000; c++) begin
      wingame = ($urandom_range(299) == 0);
      winrnd  = ($urandom_range(299) == 0);
      foul    = ($urandom_range(299) == 0);
      sypush  = ($urandom_range(299) == 0);
      if ($urandom_range(499) == 0) mute = ~mute;
      if ($urandom_range(5999) == 0) begin
        rst = 1'b0;
        step(2);
        rst = 1'b1;
      end
      step(1);
    end
    {wingame, winrnd, foul, sypush} = 4'b0;
    wait_quiet("rand", 8000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
